gcd_binary: RTL and testbench
=============================

Name: gcd_binary

Overview:
- Parametrised multi-cycle GCD engine using the binary (Stein) algorithm: shift and subtract only, no divider.
- Successor to the fixed 8-bit GCD top: adds WIDTH parametrisation, a start/busy/finish handshake, zero-operand handling with an error flag, and a cycle-count output for performance checks.
- Sits behind a controller that loads operands, pulses start, and reads GCD once finish is high.

Parameters:
- WIDTH, 8, operand and result width in bits (>=2).
- CYC_W, 8, width of the cycles counter; saturates at all-ones.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous active-low reset.
- start  in  1  request; sampled on rising clk edges.
- A  in  WIDTH  operand A; sampled only on an accepted start.
- B  in  WIDTH  operand B; sampled only on an accepted start.
- GCD  out  WIDTH  result; valid and held while finish=1.
- finish  out  1  level; high in DONE until the next accepted start.
- busy  out  1  high in STRIP or REDUCE.
- zero_err  out  1  high with finish when A==0 and B==0.
- cycles  out  CYC_W  number of edges spent in STRIP/REDUCE for the last operation.

Behaviour:
- Reset (reset=0, async): state=IDLE; GCD, finish, busy, zero_err, cycles, internal a/b/k all 0.
- States: IDLE, STRIP, REDUCE, DONE. Registers: a, b (WIDTH bits); k (clog2(WIDTH+1) bits), the count of common factors of 2.
- Start acceptance: start=1 at an edge while in IDLE or DONE.
  - On acceptance: finish<=0, zero_err<=0, cycles<=0.
  - Then latch a=A, b=B, k=0.
  - If A==0 or B==0: go directly to DONE; GCD<=A|B; zero_err<=(A==0 && B==0); cycles stays 0.
  - Otherwise go to STRIP.
- start while busy: ignored; no effect on any register.
- STRIP (one action per edge, cycles++):
  - If a[0]==0 and b[0]==0: a>>=1, b>>=1, k++.
  - Else: go to REDUCE, data unchanged.
- REDUCE (first matching rule per edge, cycles++):
  - a==b: GCD<=a<<k, go to DONE.
  - a even: a>>=1.
  - b even: b>>=1.
  - a>b: a<=(a-b)>>1.
  - else: b<=(b-a)>>1.
- Width rules:
  - Subtraction is always larger minus smaller, so there is no underflow.
  - a and b never reach 0 in REDUCE.
  - a<<k fits in WIDTH because the result is <= min(A,B).
- DONE: finish=1; GCD, zero_err and cycles held. A new start is accepted in DONE exactly as in IDLE.
- Latency: finish is visible after edge 1+cycles counted from the accepting edge. Worst case is <=2*WIDTH+2 edges in STRIP/REDUCE.
- cycles saturates at 2^CYC_W-1 and never wraps.
- reset asserted mid-operation: immediate return to IDLE with all outputs 0; any partial result is discarded.
- Simultaneous start and reset=0: reset wins.

Test Plan:
- Reset, A=80, B=10, pulse start -> busy next cycle; finish=1, GCD=10, zero_err=0, cycles=6. Then A=80, B=40 with start in DONE -> GCD=40, cycles=6.
- A=17, B=13 -> GCD=1, cycles=7. A=255, B=255 -> GCD=255, cycles=2.
- A=0, B=12 -> finish one edge after start, GCD=12, zero_err=0, cycles=0. A=0, B=0 -> GCD=0, zero_err=1.
- Start A=80, B=10, then pulse start with A=3, B=9 while busy -> second start ignored; result GCD=10. Inputs changing while busy have no effect.
- Drive reset low on the 3rd busy cycle of A=80, B=40 -> all outputs 0 immediately (asynchronous, before the next edge). After release, start A=48, B=18 -> GCD=6.
- WIDTH=16 instance, A=65535, B=1 -> GCD=1, cycles<=34; random 1000-pair self-check against a reference model, including cycles monotonic saturation with CYC_W=4.

Source files
------------

// File: rtl/gcd_binary.sv
// -----------------------------------------------------------------------------
// gcd_binary
//
// Multi-cycle greatest-common-divisor engine using the binary (Stein)
// algorithm.  Only shifts, compares and subtractions are used; there is no
// divider.  A controller loads A/B, pulses start, waits for finish and then
// reads GCD.  The engine also reports a zero-operand error and the number of
// clock edges the last operation spent computing.
//
// Parameters
//   WIDTH  operand/result width in bits (>= 2)
//   CYC_W  width of the cycles counter; the counter saturates at all-ones
//
// Ports
//   clk       in   1      system clock, rising edge
//   reset     in   1      asynchronous reset, active low
//   start     in   1      operation request, accepted in IDLE or DONE only
//   A, B      in   WIDTH  operands, captured on an accepted start
//   GCD       out  WIDTH  result, valid and held while finish is high
//   finish    out  1      high in DONE until the next accepted start
//   busy      out  1      high while computing (STRIP or REDUCE)
//   zero_err  out  1      high with finish when both operands were zero
//   cycles    out  CYC_W  edges spent in STRIP/REDUCE by the last operation
// -----------------------------------------------------------------------------
module gcd_binary #(
    parameter int WIDTH = 8,
    parameter int CYC_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] GCD,
    output logic             finish,
    output logic             busy,
    output logic             zero_err,
    output logic [CYC_W-1:0] cycles
);

    // k counts the common factors of two removed in STRIP.  It never exceeds
    // WIDTH-1, so clog2(WIDTH+1) bits are always sufficient.
    localparam int K_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STRIP  = 2'd1,
        S_REDUCE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic [K_W-1:0]   k_q,      k_d;
    logic [WIDTH-1:0] gcd_q,    gcd_d;
    logic             zerr_q,   zerr_d;
    logic [CYC_W-1:0] cyc_q,    cyc_d;

    // Helper terms for the next-state logic.
    logic             can_accept;
    logic             a_zero;
    logic             b_zero;
    logic [CYC_W-1:0] cyc_inc;
    logic [WIDTH-1:0] a_minus_b;
    logic [WIDTH-1:0] b_minus_a;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            k_q     <= '0;
            gcd_q   <= '0;
            zerr_q  <= 1'b0;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            k_q     <= k_d;
            gcd_q   <= gcd_d;
            zerr_q  <= zerr_d;
            cyc_q   <= cyc_d;
        end
    end

    // -------------------------------------------------------------------------
    // Shared combinational terms
    // -------------------------------------------------------------------------
    always_comb begin
        can_accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));
        a_zero     = (A == '0);
        b_zero     = (B == '0);
        // Saturating increment: once all-ones the counter stays put instead
        // of wrapping back to a misleadingly small value.
        cyc_inc    = (cyc_q == '1) ? cyc_q : (cyc_q + CYC_W'(1));
        // Both differences are formed, only the non-negative one is used, so
        // the selected subtraction never underflows.
        a_minus_b  = a_q - b_q;
        b_minus_a  = b_q - a_q;
    end

    // -------------------------------------------------------------------------
    // Next-state and datapath update
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        k_d     = k_q;
        gcd_d   = gcd_q;
        zerr_d  = zerr_q;
        cyc_d   = cyc_q;

        case (state_q)
            // IDLE and DONE accept a new operation identically.  GCD is left
            // alone on a normal start; it is only meaningful while finish=1.
            S_IDLE, S_DONE: begin
                if (can_accept) begin
                    zerr_d = 1'b0;
                    cyc_d  = '0;
                    a_d    = A;
                    b_d    = B;
                    k_d    = '0;
                    if (a_zero || b_zero) begin
                        // gcd(x,0) = x; gcd(0,0) is undefined and flagged.
                        state_d = S_DONE;
                        gcd_d   = A | B;
                        zerr_d  = a_zero && b_zero;
                    end else begin
                        state_d = S_STRIP;
                    end
                end
            end

            // Remove common factors of two, remembering how many in k.
            S_STRIP: begin
                cyc_d = cyc_inc;
                if (!a_q[0] && !b_q[0]) begin
                    a_d = a_q >> 1;
                    b_d = b_q >> 1;
                    k_d = k_q + K_W'(1);
                end else begin
                    state_d = S_REDUCE;
                end
            end

            // At least one of a/b is odd here.  Halving an even value or
            // replacing the larger by half the (even) difference of two odd
            // values preserves the odd part of the gcd.  Neither value can
            // reach zero, so the loop always terminates on a == b.
            S_REDUCE: begin
                cyc_d = cyc_inc;
                if (a_q == b_q) begin
                    // Result divides min(A,B), so the shift cannot overflow.
                    gcd_d   = a_q << k_q;
                    state_d = S_DONE;
                end else if (!a_q[0]) begin
                    a_d = a_q >> 1;
                end else if (!b_q[0]) begin
                    b_d = b_q >> 1;
                end else if (a_q > b_q) begin
                    a_d = a_minus_b >> 1;
                end else begin
                    b_d = b_minus_a >> 1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // All outputs come straight from registers (or decode of the state
    // register), so an asynchronous reset clears them without waiting for a
    // clock edge.
    assign GCD      = gcd_q;
    assign finish   = (state_q == S_DONE);
    assign busy     = (state_q == S_STRIP) || (state_q == S_REDUCE);
    assign zero_err = zerr_q;
    assign cycles   = cyc_q;

endmodule

// File: tb/tb_gcd_binary.sv
// -----------------------------------------------------------------------------
// tb_gcd_binary
//
// Directed bench for gcd_binary.  An 8-bit instance (CYC_W=8) covers the
// handshake, zero operands, ignored starts, back-to-back starts and the
// asynchronous reset.  A 16-bit instance with a 4-bit cycles counter covers
// wide operands, a pseudo-random sweep against a Euclid reference and
// saturation of the cycles counter.
// -----------------------------------------------------------------------------
module tb_gcd_binary;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic        start8;
    logic [7:0]  a8, b8;
    logic [7:0]  gcd8;
    logic        fin8, busy8, zerr8;
    logic [7:0]  cyc8;

    logic        start16;
    logic [15:0] a16, b16;
    logic [15:0] gcd16;
    logic        fin16, busy16, zerr16;
    logic [3:0]  cyc16;

    int n_checks = 0;
    int n_fail   = 0;

    gcd_binary #(.WIDTH(8), .CYC_W(8)) u_dut8 (
        .clk      (clk),
        .reset    (reset),
        .start    (start8),
        .A        (a8),
        .B        (b8),
        .GCD      (gcd8),
        .finish   (fin8),
        .busy     (busy8),
        .zero_err (zerr8),
        .cycles   (cyc8)
    );

    gcd_binary #(.WIDTH(16), .CYC_W(4)) u_dut16 (
        .clk      (clk),
        .reset    (reset),
        .start    (start16),
        .A        (a16),
        .B        (b16),
        .GCD      (gcd16),
        .finish   (fin16),
        .busy     (busy16),
        .zero_err (zerr16),
        .cycles   (cyc16)
    );

    // Euclid by remainder: an algorithm independent of the design's.
    function automatic int ref_gcd(input int x, input int y);
        int t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Launch one 8-bit operation and wait for finish.  edges counts negedges
    // after the accepting posedge up to and including the one where finish
    // is first seen; busy_1st/fin_1st are sampled one cycle after the start.
    task automatic go8(input logic [7:0] a, input logic [7:0] b,
                       output int edges, output logic busy_1st,
                       output logic fin_1st);
        @(negedge clk);
        start8 = 1'b1;
        a8     = a;
        b8     = b;
        @(negedge clk);
        start8   = 1'b0;
        edges    = 1;
        busy_1st = busy8;
        fin_1st  = fin8;
        while (!fin8 && edges < 100) begin
            @(negedge clk);
            edges++;
        end
        $display("gcd8  A=%0d B=%0d -> GCD=%0d zero_err=%0d cycles=%0d edges=%0d",
                 a, b, gcd8, zerr8, cyc8, edges);
    endtask

    // 16-bit variant; also watches that cycles never decreases while busy.
    task automatic go16(input logic [15:0] a, input logic [15:0] b,
                        output int edges, output logic mono_bad);
        logic [3:0] prev;
        @(negedge clk);
        start16 = 1'b1;
        a16     = a;
        b16     = b;
        @(negedge clk);
        start16  = 1'b0;
        edges    = 1;
        mono_bad = 1'b0;
        prev     = cyc16;
        while (!fin16 && edges < 100) begin
            @(negedge clk);
            edges++;
            if (cyc16 < prev) mono_bad = 1'b1;
            prev = cyc16;
        end
        $display("gcd16 A=%0d B=%0d -> GCD=%0d cycles=%0d edges=%0d",
                 a, b, gcd16, cyc16, edges);
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        start8  = 1'b1;          // start held during reset must be ignored
        a8      = 8'd80;
        b8      = 8'd10;
        start16 = 1'b0;
        a16     = '0;
        b16     = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (gcd8 !== 8'd0 || fin8 !== 1'b0 || busy8 !== 1'b0 ||
            zerr8 !== 1'b0 || cyc8 !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_state: got gcd=%0d fin=%0b busy=%0b zerr=%0b cyc=%0d required all 0",
                     gcd8, fin8, busy8, zerr8, cyc8);
        end
        start8 = 1'b0;
        reset  = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy8 !== 1'b0 || fin8 !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got busy=%0b fin=%0b required 0 0", busy8, fin8);
        end
        $display("reset applied and released");
    endtask

    task automatic test_basic();
        int   e;
        logic bf, ff;
        go8(8'd80, 8'd10, e, bf, ff);
        n_checks++;
        if (bf !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_busy: got %0b required 1", bf);
        end
        n_checks++;
        if (fin8 !== 1'b1 || gcd8 !== 8'd10) begin
            n_fail++;
            $display("FAIL basic_gcd: got fin=%0b gcd=%0d required fin=1 gcd=10", fin8, gcd8);
        end
        n_checks++;
        if (zerr8 !== 1'b0 || cyc8 !== 8'd6) begin
            n_fail++;
            $display("FAIL basic_cycles: got zerr=%0b cyc=%0d required zerr=0 cyc=6", zerr8, cyc8);
        end
        n_checks++;
        if (e != 7) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d edges required 7", e);
        end
    endtask

    task automatic test_back_to_back();
        int   e;
        logic bf, ff;
        go8(8'd80, 8'd40, e, bf, ff);   // started while in DONE
        n_checks++;
        if (ff !== 1'b0 || bf !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_restart: got fin=%0b busy=%0b required fin=0 busy=1", ff, bf);
        end
        n_checks++;
        if (gcd8 !== 8'd40 || cyc8 !== 8'd6 || fin8 !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_result: got gcd=%0d cyc=%0d fin=%0b required 40 6 1", gcd8, cyc8, fin8);
        end
    endtask

    task automatic test_odd_equal();
        int   e;
        logic bf, ff;
        go8(8'd17, 8'd13, e, bf, ff);
        n_checks++;
        if (gcd8 !== 8'd1 || cyc8 !== 8'd7) begin
            n_fail++;
            $display("FAIL coprime: got gcd=%0d cyc=%0d required 1 7", gcd8, cyc8);
        end
        go8(8'd255, 8'd255, e, bf, ff);
        n_checks++;
        if (gcd8 !== 8'd255 || cyc8 !== 8'd2 || e != 3) begin
            n_fail++;
            $display("FAIL equal: got gcd=%0d cyc=%0d edges=%0d required 255 2 3", gcd8, cyc8, e);
        end
    endtask

    task automatic test_zero();
        int   e;
        logic bf, ff;
        go8(8'd0, 8'd12, e, bf, ff);
        n_checks++;
        if (e != 1 || bf !== 1'b0 || gcd8 !== 8'd12 || zerr8 !== 1'b0 || cyc8 !== 8'd0) begin
            n_fail++;
            $display("FAIL zero_a: got edges=%0d busy=%0b gcd=%0d zerr=%0b cyc=%0d required 1 0 12 0 0",
                     e, bf, gcd8, zerr8, cyc8);
        end
        go8(8'd0, 8'd0, e, bf, ff);
        n_checks++;
        if (e != 1 || gcd8 !== 8'd0 || zerr8 !== 1'b1 || fin8 !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_both: got edges=%0d gcd=%0d zerr=%0b fin=%0b required 1 0 1 1",
                     e, gcd8, zerr8, fin8);
        end
        go8(8'd9, 8'd0, e, bf, ff);     // also clears the earlier zero_err
        n_checks++;
        if (gcd8 !== 8'd9 || zerr8 !== 1'b0 || cyc8 !== 8'd0) begin
            n_fail++;
            $display("FAIL zero_b: got gcd=%0d zerr=%0b cyc=%0d required 9 0 0", gcd8, zerr8, cyc8);
        end
    endtask

    task automatic test_busy_ignore();
        int e;
        @(negedge clk);
        start8 = 1'b1;
        a8     = 8'd80;
        b8     = 8'd10;
        @(negedge clk);
        start8 = 1'b0;
        a8     = 8'd200;
        b8     = 8'd7;
        @(negedge clk);
        start8 = 1'b1;                   // second request while busy
        a8     = 8'd3;
        b8     = 8'd9;
        @(negedge clk);
        start8 = 1'b0;
        a8     = 8'd0;
        b8     = 8'd0;
        e = 3;
        while (!fin8 && e < 100) begin
            @(negedge clk);
            e++;
        end
        $display("gcd8  A=80 B=10 with start while busy -> GCD=%0d cycles=%0d", gcd8, cyc8);
        n_checks++;
        if (fin8 !== 1'b1 || gcd8 !== 8'd10 || cyc8 !== 8'd6 || zerr8 !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_ignore: got fin=%0b gcd=%0d cyc=%0d zerr=%0b required 1 10 6 0",
                     fin8, gcd8, cyc8, zerr8);
        end
    endtask

    task automatic test_async_reset();
        int   e;
        logic bf, ff;
        @(negedge clk);
        start8 = 1'b1;
        a8     = 8'd80;
        b8     = 8'd40;
        @(negedge clk);                  // busy cycle 1
        start8 = 1'b0;
        @(negedge clk);                  // busy cycle 2
        @(negedge clk);                  // busy cycle 3
        n_checks++;
        if (busy8 !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_pre: got busy=%0b required 1", busy8);
        end
        reset = 1'b0;
        #1;                              // well before the next rising edge
        n_checks++;
        if (gcd8 !== 8'd0 || fin8 !== 1'b0 || busy8 !== 1'b0 ||
            zerr8 !== 1'b0 || cyc8 !== 8'd0) begin
            n_fail++;
            $display("FAIL areset_clear: got gcd=%0d fin=%0b busy=%0b zerr=%0b cyc=%0d required all 0",
                     gcd8, fin8, busy8, zerr8, cyc8);
        end
        $display("async reset asserted mid-operation");
        @(negedge clk);
        reset = 1'b1;
        go8(8'd48, 8'd18, e, bf, ff);
        n_checks++;
        if (gcd8 !== 8'd6 || cyc8 !== 8'd7) begin
            n_fail++;
            $display("FAIL areset_after: got gcd=%0d cyc=%0d required 6 7", gcd8, cyc8);
        end
    endtask

    task automatic test_wide();
        int   e;
        logic mb;
        go16(16'hFFFF, 16'd1, e, mb);
        n_checks++;
        if (gcd16 !== 16'd1 || fin16 !== 1'b1 || e - 1 > 34) begin
            n_fail++;
            $display("FAIL wide_max: got gcd=%0d fin=%0b cycles_edges=%0d required 1 1 <=34",
                     gcd16, fin16, e - 1);
        end
        // 17 edges of work exceed the 4-bit counter, so it must read 15.
        n_checks++;
        if (cyc16 !== 4'd15 || mb) begin
            n_fail++;
            $display("FAIL wide_saturate: got cyc=%0d mono_bad=%0b required 15 0", cyc16, mb);
        end
    endtask

    task automatic test_random();
        int          e;
        logic        mb;
        logic [15:0] x, y;
        int          exp_cyc;
        for (int i = 0; i < 1000; i++) begin
            if (i % 2 == 0) begin
                // shared factor (often with powers of two) to exercise STRIP
                int g;
                g = int'($urandom_range(1, 64));
                x = 16'(g * int'($urandom_range(1, 1023)));
                y = 16'(g * int'($urandom_range(1, 1023)));
            end else begin
                x = 16'($urandom_range(1, 65535));
                y = 16'($urandom_range(1, 65535));
            end
            go16(x, y, e, mb);
            n_checks++;
            if (fin16 !== 1'b1 || int'(gcd16) != ref_gcd(int'(x), int'(y))) begin
                n_fail++;
                $display("FAIL rand_gcd: A=%0d B=%0d got %0d required %0d",
                         x, y, gcd16, ref_gcd(int'(x), int'(y)));
            end
            exp_cyc = (e - 1 > 15) ? 15 : e - 1;
            n_checks++;
            if (int'(cyc16) != exp_cyc || mb || e - 1 > 34) begin
                n_fail++;
                $display("FAIL rand_cycles: A=%0d B=%0d got cyc=%0d edges=%0d mono_bad=%0b required cyc=%0d edges<=35",
                         x, y, cyc16, e, mb, exp_cyc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_odd_equal();
        test_zero();
        test_busy_ignore();
        test_async_reset();
        test_wide();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
